// File: rtl/mem_read_port_if.sv
// mem_read_port_if: word-read handshake between the load port and data memory
interface mem_read_port_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/mem_read_port.sv
// mem_read_port: load port issuing word reads and extracting byte/half/word results.
// Optional feature macro: MEM_READ_SUBWORD_EN (byte/halfword loads with extension).
module mem_read_port #(
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             addr,
    input  logic [1:0]              size,
    input  logic                    unsigned_ld,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             rdata,
    mem_read_port_if.master         mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, nxt;
    logic [7:0]  cnt;
    logic        bad, acc, ack_ok, tmo;
    logic [31:0] ld_val;

    assign acc    = state == IDLE && start;
    assign ack_ok = state == REQ && mem.mem_ack;
    assign tmo    = state == REQ && !mem.mem_ack && cnt == 8'(TIMEOUT - 1);

`ifdef MEM_READ_SUBWORD_EN
    logic [1:0]  lo_q, size_q;
    logic        uns_q;
    logic [7:0]  b;
    logic [15:0] h;

    assign bad = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    assign b   = mem.mem_rdata[{lo_q, 3'b000} +: 8];
    assign h   = mem.mem_rdata[{lo_q[1], 4'b0000} +: 16];
    assign ld_val = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} :
                    size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : mem.mem_rdata;

    // Remember lane and extension mode of the accepted load for use at ack time
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            lo_q   <= 2'b00;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
        end else if (acc) begin
            lo_q   <= addr[1:0];
            size_q <= size;
            uns_q  <= unsigned_ld;
        end
`else
    logic unused_ok;

    assign bad       = addr[1:0] != 2'b00;
    assign ld_val    = mem.mem_rdata;
    assign unused_ok = ^{size, unsigned_ld};
`endif

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    // Next state and state-decoded outputs
    always_comb begin
        nxt         = state;
        busy        = state != IDLE;
        done        = state == DONE;
        mem.mem_req = state == REQ;
        if (acc)                  nxt = bad ? DONE : REQ;
        else if (ack_ok || tmo)   nxt = DONE;
        else if (state == DONE)   nxt = IDLE;
    end

    // Wait counter, address register, result and error status
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt          <= 8'd0;
            err          <= 1'b0;
            rdata        <= 32'd0;
            mem.mem_addr <= 32'd0;
        end else begin
            cnt <= (state == REQ && !mem.mem_ack) ? cnt + 8'd1 : 8'd0;
            if (acc && bad)  err <= 1'b1;
            if (acc && !bad) mem.mem_addr <= {addr[31:2], 2'b00};
            if (ack_ok) begin
                rdata <= ld_val;
                err   <= 1'b0;
            end
            if (tmo) err <= 1'b1;
        end
endmodule

// File: tb/tb_mem_read_port.sv
// tb_mem_read_port: scoreboard bench for mem_read_port
module tb_mem_read_port;
    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        u;
        logic [7:0]  ack_at;
        logic [31:0] d;
    } vec_t;

    typedef struct packed {
        logic        e;
        logic [31:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, unsigned_ld;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] prev;
    int          n_vec = 0, n_bad = 0;
    exp_t        sb[$];
    vec_t        vt[9];

    mem_read_port_if bus ();

    mem_read_port #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .size(size),
        .unsigned_ld(unsigned_ld), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input vec_t t, input logic [31:0] p, output logic e,
                                  output logic [31:0] r, output int dc, output int rc);
        logic b_ad;
        logic [31:0] v;
`ifdef MEM_READ_SUBWORD_EN
        logic [7:0]  b;
        logic [15:0] h;
        b_ad = (t.sz == 2'd3) || (t.sz == 2'd1 && t.a[0]) || (t.sz == 2'd2 && t.a[1:0] != 2'd0);
        b = 8'(t.d >> (8 * t.a[1:0]));
        h = t.a[1] ? t.d[31:16] : t.d[15:0];
        v = t.sz == 2'd0 ? (t.u ? {24'h0, b} : {{24{b[7]}}, b}) :
            t.sz == 2'd1 ? (t.u ? {16'h0, h} : {{16{h[15]}}, h}) : t.d;
`else
        b_ad = t.a[1:0] != 2'd0;
        v = t.d;
`endif
        if (b_ad) begin
            e = 1'b1; r = p; dc = 1; rc = 0;
        end else if (t.ack_at == 0 || int'(t.ack_at) > TO) begin
            e = 1'b1; r = p; dc = TO + 1; rc = TO;
        end else begin
            e = 1'b0; r = v; dc = int'(t.ack_at) + 1; rc = int'(t.ack_at);
        end
    endfunction

    task automatic load(input vec_t t);
        logic e;
        logic [31:0] r;
        int dc, rc, reqn;
        bit seen;
        exp_t x;
        model(t, prev, e, r, dc, rc);
        sb.push_back('{e: e, r: r});
        prev = r;
        @(negedge clk);
        start = 1'b1; addr = t.a; size = t.sz; unsigned_ld = t.u;
        @(posedge clk); #1;
        start = 1'b0;
        reqn = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (bus.mem_req) begin
                reqn++;
                chk("mem_addr", bus.mem_addr, {t.a[31:2], 2'b00});
                bus.mem_ack   = (reqn == int'(t.ack_at));
                bus.mem_rdata = (reqn == int'(t.ack_at)) ? t.d : $urandom;
            end else bus.mem_ack = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", n, dc);
                chk("req_cycles", reqn, rc);
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    x = sb.pop_front();
                    chk("err", {31'd0, err}, {31'd0, x.e});
                    chk("rdata", rdata, x.r);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) chk("done_wait", 0, 1);
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        vt = '{
            '{32'h10, 2'd2, 1'b0, 8'd3, 32'hDEAD_BEEF},
            '{32'h13, 2'd0, 1'b0, 8'd1, 32'h80FF_1234},
            '{32'h13, 2'd0, 1'b1, 8'd2, 32'h80FF_1234},
            '{32'h22, 2'd1, 1'b0, 8'd1, 32'h8001_7FFF},
            '{32'h21, 2'd1, 1'b0, 8'd1, 32'h8001_7FFF},
            '{32'h20, 2'd2, 1'b0, 8'd0, 32'hAAAA_5555},
            '{32'h24, 2'd2, 1'b0, 8'd4, 32'hCAFE_F00D},
            '{32'h14, 2'd0, 1'b0, 8'd1, 32'h80FF_1234},
            '{32'h18, 2'd3, 1'b0, 8'd1, 32'h1111_2222}
        };
        rst = 1'b0; start = 1'b0; addr = 32'd0; size = 2'd0; unsigned_ld = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        prev = 32'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) load(vt[i]);
        @(negedge clk);
        start = 1'b1; addr = 32'h40; size = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.mem_req}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_rdata", rdata, 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("late_ack_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("late_ack_rdata", rdata, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        bus.mem_ack = 1'b0;
        prev = 32'd0;
        load('{32'h44, 2'd2, 1'b0, 8'd2, 32'h0BAD_F00D});
        if (sb.size() != 0) chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_read_port.md
# mem_read_port

Read-side memory port for the multi-cycle datapath: accepts a load request from the control unit, issues a word read to data memory over a req/ack handshake, and extracts the byte, halfword or word. It sign- or zero-extends the result into a held 32-bit read-data register, which plays the memory-data-register role. It is the reading counterpart of the write-enabled datapath registers and sits between the control FSM and the data memory.

## Interface
- TIMEOUT, default 15: max cycles mem_req may stay high without mem_ack before the access is aborted; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  load request from control; sampled only in IDLE.
- addr  in  32  byte address of the load; captured with start.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- unsigned_ld  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned, reserved size, or timeout.
- rdata  out  32  extracted load result, held until the next successful load.
- mem_req  out  1  read request to memory.
- mem_addr  out  32  word address {addr[31:2],2'b00}, registered.
- mem_ack  in  1  memory response; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read word.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: busy=0, mem_req=0. On start=1, addr, size and unsigned_ld are latched.
  - Aligned, legal size: go to REQ and load mem_addr.
  - Otherwise: go to DONE with err=1, issue no memory access, leave rdata unchanged.
- Alignment rule: halfword needs addr[0]=0. Word needs addr[1:0]=00. Byte is always aligned.
- REQ: mem_req=1 and mem_addr stable until mem_ack is sampled high.
  - On mem_ack: mem_rdata is captured and extracted into rdata, err is cleared, and the state moves to DONE.
  - A cycle counter increments each REQ cycle without ack. When it reaches TIMEOUT, mem_req drops, rdata is unchanged, and the state moves to DONE with err=1.
- DONE: done=1 for exactly one cycle, then IDLE. err holds its value until the next DONE.
- Extraction is little-endian.
  - Byte lane = mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]].
  - Halfword lane = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - Extension is by unsigned_ld.
- start outside IDLE is ignored. mem_ack outside REQ is ignored.
- Reset (rst=0, any time): state IDLE; busy, done, err and mem_req = 0; mem_addr and rdata = 0; counter = 0. An in-flight access is abandoned and mem_req drops immediately.

## Timing
- start high at edge 0 → mem_req high from cycle 1.
- mem_ack sampled at edge k → done and new rdata visible in cycle k+1.
- Minimum start-to-done: 2 cycles, with ack in the first REQ cycle.
- Minimum spacing between accepted starts: 3 cycles.
- Error path (misaligned or reserved size): done=1, err=1 in cycle 1, with no mem_req.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then done=1, err=1 in the next cycle.
- mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success; ack wins.

## Configuration
- MEM_READ_SUBWORD_EN defined: byte and halfword loads, lane extraction, sign/zero extension and the halfword alignment check are all supported.
- MEM_READ_SUBWORD_EN undefined:
  - size and unsigned_ld are ignored; every load is a word load.
  - Misaligned means addr[1:0]≠00.
  - rdata = mem_rdata; no extraction logic is built.

## Test plan
- Word load: addr=0x0000_0010, size=10, ack on the 3rd REQ cycle, mem_rdata=0xDEAD_BEEF → mem_addr=0x10, done at cycle 4, rdata=0xDEAD_BEEF, err=0.
- Byte loads: addr=0x13, mem_rdata=0x80FF_1234. Signed → rdata=0xFFFF_FF80. Unsigned (unsigned_ld=1) → rdata=0x0000_0080.
- Halfword: addr=0x22, signed, mem_rdata=0x8001_7FFF → rdata=0xFFFF_8001. With addr=0x21 → done=1, err=1 at cycle 1, mem_req never asserted, rdata unchanged.
- Timeout: TIMEOUT=4, mem_ack held low → mem_req high for 4 cycles, done=1, err=1 on the next cycle, rdata unchanged. Separately, ack in the 4th cycle → success.
- Reset mid-REQ: drive rst=0 while mem_req=1 → mem_req, busy, rdata = 0 without waiting for a clock. A later ack is ignored, and a new start after reset works normally.
- Build without MEM_READ_SUBWORD_EN: addr=0x13, size=00 → err=1. addr=0x14 with any size → full word returned.
